// File: rtl/led_activity_driver_if.sv
// Bundles the indicator-side inputs and LED-pin outputs of led_activity_driver.
// The master modport belongs to the upstream indicator and board side.
// The slave modport belongs to the driver itself.
interface led_activity_driver_if #(
  parameter int N = 8
);
  logic [N-1:0] led_in;
  logic [N-1:0] blink_en;
  logic [3:0]   brightness;
  logic [N-1:0] led_lit;
  logic [N-1:0] led_out;
  logic         tick;

  modport master (
    output led_in, blink_en, brightness,
    input  led_lit, led_out, tick
  );

  modport slave (
    input  led_in, blink_en, brightness,
    output led_lit, led_out, tick
  );
endinterface

// File: rtl/led_activity_driver.sv
// Stretches short activity pulses to a visible on-time, then applies blink and global PWM brightness.
// Latency: led_in sampled at edge n shows on led_lit and led_out after edge n+2.
// Backpressure: none; every input is accepted on every cycle.
module led_activity_driver #(
  parameter int N        = 8,
  parameter int PRESCALE = 28000,
  parameter int HOLD     = 50,
  parameter int BLINK    = 250,
  parameter bit INV      = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  led_activity_driver_if.slave  bus
);

  localparam int PW = $clog2(PRESCALE);
  localparam int BW = (BLINK > 1) ? $clog2(BLINK) : 1;
  localparam logic [PW-1:0] PRE_MAX   = PW'(PRESCALE - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK - 1);
  localparam logic [7:0]    HOLD_INIT = 8'(HOLD);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_HOLD   = 2'd2
  } state_e;

  logic [N-1:0]  in_q, in_d;
  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic          tick_q, tick_d;
  logic [3:0]    pwm_cnt_q, pwm_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  state_e        state_q [N];
  state_e        state_d [N];
  logic [7:0]    hold_cnt_q [N];
  logic [7:0]    hold_cnt_d [N];
  logic [N-1:0]  lit;
  logic [N-1:0]  led_lit_q, led_lit_d;
  logic [N-1:0]  led_out_q, led_out_d;
  logic          duty_on;

  // Time base: input capture, tick prescaler, free-running PWM counter and blink phase
  always_comb begin
    in_d        = bus.led_in;
    tick_d      = (pre_cnt_q == PRE_MAX);
    pre_cnt_d   = tick_d ? '0 : pre_cnt_q + PW'(1);
    pwm_cnt_d   = pwm_cnt_q + 4'd1;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (tick_q) begin
      if (blink_cnt_q == BLINK_MAX) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  // Per-channel pulse stretcher; a fresh input pulse always beats hold expiry
  always_comb begin
    for (int i = 0; i < N; i++) begin
      state_d[i]    = state_q[i];
      hold_cnt_d[i] = hold_cnt_q[i];
      lit[i]        = (state_q[i] != S_IDLE);
      case (state_q[i])
        S_IDLE: begin
          if (in_q[i]) state_d[i] = S_ACTIVE;
        end
        S_ACTIVE: begin
          if (!in_q[i]) begin
            state_d[i]    = S_HOLD;
            hold_cnt_d[i] = HOLD_INIT;
          end
        end
        S_HOLD: begin
          if (in_q[i]) begin
            state_d[i] = S_ACTIVE;
          end else if (tick_q) begin
            hold_cnt_d[i] = hold_cnt_q[i] - 8'd1;
            if (hold_cnt_q[i] == 8'd1) state_d[i] = S_IDLE;
          end
        end
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

  // Output stage: blink masks lit channels during the dark phase, then PWM and polarity
  always_comb begin
    duty_on   = (bus.brightness == 4'd15) || (pwm_cnt_q < bus.brightness);
    led_lit_d = lit;
    for (int i = 0; i < N; i++) begin
      led_out_d[i] = (lit[i] & (~bus.blink_en[i] | phase_q) & duty_on) ^ INV;
    end
  end

  // State registers; reset drops every channel to IDLE and the pins to their dark level at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q        <= '0;
      pre_cnt_q   <= '0;
      tick_q      <= 1'b0;
      pwm_cnt_q   <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      led_lit_q   <= '0;
      led_out_q   <= {N{INV}};
      for (int i = 0; i < N; i++) begin
        state_q[i]    <= S_IDLE;
        hold_cnt_q[i] <= '0;
      end
    end else begin
      in_q        <= in_d;
      pre_cnt_q   <= pre_cnt_d;
      tick_q      <= tick_d;
      pwm_cnt_q   <= pwm_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      led_lit_q   <= led_lit_d;
      led_out_q   <= led_out_d;
      for (int i = 0; i < N; i++) begin
        state_q[i]    <= state_d[i];
        hold_cnt_q[i] <= hold_cnt_d[i];
      end
    end
  end

  assign bus.led_lit = led_lit_q;
  assign bus.led_out = led_out_q;
  assign bus.tick    = tick_q;

endmodule

// File: tb/tb_led_activity_driver.sv
// Drives two driver instances (active-high and active-low pins, different tick rates) with one stimulus.
// Expected outputs come from a history-based model of the stretch, blink and PWM rules.
module tb_led_activity_driver;
  localparam int N    = 8;
  localparam int MAXC = 8192;
  localparam int P0 = 4, H0 = 3, B0 = 3;
  localparam bit I0 = 1'b0;
  localparam int P1 = 2, H1 = 3, B1 = 3;
  localparam bit I1 = 1'b1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] led_in = '0;
  logic [N-1:0] blink_en = '0;
  logic [3:0]   brightness = 4'd15;
  int           tests = 0;
  int           fails = 0;
  int           cyc = 0;

  // Inputs as sampled at each rising edge since the last reset release
  logic [N-1:0] hin [MAXC];
  logic [N-1:0] hbe [MAXC];
  logic [3:0]   hbr [MAXC];

  led_activity_driver_if #(.N(N)) if0 ();
  led_activity_driver_if #(.N(N)) if1 ();

  assign if0.led_in = led_in;
  assign if0.blink_en = blink_en;
  assign if0.brightness = brightness;
  assign if1.led_in = led_in;
  assign if1.blink_en = blink_en;
  assign if1.brightness = brightness;

  led_activity_driver #(.N(N), .PRESCALE(P0), .HOLD(H0), .BLINK(B0), .INV(I0)) dut0 (
    .clk(clk), .rst(rst), .bus(if0)
  );
  led_activity_driver #(.N(N), .PRESCALE(P1), .HOLD(H1), .BLINK(B1), .INV(I1)) dut1 (
    .clk(clk), .rst(rst), .bus(if1)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc <= 0;
    end else if (cyc < MAXC - 1) begin
      cyc <= cyc + 1;
      hin[cyc+1] <= led_in;
      hbe[cyc+1] <= blink_en;
      hbr[cyc+1] <= brightness;
    end
  end

  // Ticks strobe at cycles p, 2p, 3p, ...; count of those at or before cycle b
  function automatic int ticks_upto(int b, int p);
    return (b >= 1) ? (b / p) : 0;
  endfunction

  // A channel is lit at cycle c if its captured input was high at some cycle r < c
  // and fewer than h ticks have occurred in cycles r+2 .. c-1.
  function automatic logic [N-1:0] m_lit(int c, int p, int h);
    logic [N-1:0] r;
    r = '0;
    if (c <= 0) return r;
    for (int i = 0; i < N; i++) begin
      for (int s = c - 1; s >= 1; s--) begin
        if (ticks_upto(c - 1, p) - ticks_upto(s + 1, p) >= h) break;
        if (hin[s][i]) begin
          r[i] = 1'b1;
          break;
        end
      end
    end
    return r;
  endfunction

  // Expected {led_lit, led_out, tick} after rising edge c
  function automatic logic [2*N:0] m_exp(int c, int p, int h, int b, bit inv);
    logic [N-1:0] lp;
    logic [N-1:0] o;
    logic         ph;
    logic         duty;
    if (c == 0) return {{N{1'b0}}, {N{inv}}, 1'b0};
    lp   = m_lit(c - 1, p, h);
    ph   = (((ticks_upto(c - 2, p) / b) % 2) == 0);
    duty = (hbr[c] == 4'd15) || (((c - 1) % 16) < int'(hbr[c]));
    for (int i = 0; i < N; i++) o[i] = (lp[i] & (~hbe[c][i] | ph) & duty) ^ inv;
    return {lp, o, (c % p) == 0};
  endfunction

  task automatic test_reset();
    logic [2*N:0] e;
    int first0;
    first0 = -1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({if0.led_lit, if0.led_out, if0.tick} !== {8'h00, 8'h00, 1'b0}) begin
      fails++;
      $display("FAIL reset_dut0 got=%h exp=%h", {if0.led_lit, if0.led_out, if0.tick}, {8'h00, 8'h00, 1'b0});
    end
    tests++;
    if ({if1.led_lit, if1.led_out, if1.tick} !== {8'h00, 8'hFF, 1'b0}) begin
      fails++;
      $display("FAIL reset_dut1 got=%h exp=%h", {if1.led_lit, if1.led_out, if1.tick}, {8'h00, 8'hFF, 1'b0});
    end
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (if0.tick && first0 < 0) first0 = cyc;
      e = m_exp(cyc, P0, H0, B0, I0);
      tests++;
      if ({if0.led_lit, if0.led_out, if0.tick} !== e) begin
        fails++;
        $display("FAIL post_reset_dut0 cyc=%0d got=%h exp=%h", cyc, {if0.led_lit, if0.led_out, if0.tick}, e);
      end
    end
    tests++;
    if (first0 !== P0) begin
      fails++;
      $display("FAIL first_tick got=%0d exp=%0d", first0, P0);
    end
  endtask

  task automatic test_short_pulse();
    logic [2*N:0] e0, e1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      e0 = m_exp(cyc, P0, H0, B0, I0);
      e1 = m_exp(cyc, P1, H1, B1, I1);
      tests++;
      if ({if0.led_lit, if0.led_out, if0.tick} !== e0) begin
        fails++;
        $display("FAIL short_pulse_dut0 cyc=%0d got=%h exp=%h", cyc, {if0.led_lit, if0.led_out, if0.tick}, e0);
      end
      tests++;
      if ({if1.led_lit, if1.led_out, if1.tick} !== e1) begin
        fails++;
        $display("FAIL short_pulse_dut1 cyc=%0d got=%h exp=%h", cyc, {if1.led_lit, if1.led_out, if1.tick}, e1);
      end
      led_in = (k == 2) ? 8'h01 : 8'h00;
    end
  endtask

  task automatic test_retrigger();
    logic [2*N:0] e0, e1;
    int gap;
    int len;
    for (int off = 4; off <= 14; off++) begin
      gap = off;
      len = $urandom_range(1, 3);
      for (int k = 0; k < gap + 28; k++) begin
        @(negedge clk);
        e0 = m_exp(cyc, P0, H0, B0, I0);
        e1 = m_exp(cyc, P1, H1, B1, I1);
        tests++;
        if ({if0.led_lit, if0.led_out, if0.tick} !== e0) begin
          fails++;
          $display("FAIL retrigger_dut0 cyc=%0d got=%h exp=%h", cyc, {if0.led_lit, if0.led_out, if0.tick}, e0);
        end
        tests++;
        if ({if1.led_lit, if1.led_out, if1.tick} !== e1) begin
          fails++;
          $display("FAIL retrigger_dut1 cyc=%0d got=%h exp=%h", cyc, {if1.led_lit, if1.led_out, if1.tick}, e1);
        end
        led_in = ((k < len) || (k >= gap && k < gap + len)) ? 8'h02 : 8'h00;
      end
    end
  endtask

  task automatic test_pwm();
    logic [2*N:0] e0, e1;
    logic [3:0] blist [4];
    int on_cnt;
    int want;
    blist[0] = 4'd4; blist[1] = 4'd0; blist[2] = 4'd15; blist[3] = 4'd9;
    led_in = 8'hFF;
    blink_en = 8'h00;
    for (int j = 0; j < 4; j++) begin
      brightness = blist[j];
      on_cnt = 0;
      for (int k = 0; k < 36; k++) begin
        @(negedge clk);
        if (k >= 4 && if0.led_out[0]) on_cnt++;
        e0 = m_exp(cyc, P0, H0, B0, I0);
        e1 = m_exp(cyc, P1, H1, B1, I1);
        tests++;
        if ({if0.led_lit, if0.led_out, if0.tick} !== e0) begin
          fails++;
          $display("FAIL pwm_dut0 cyc=%0d got=%h exp=%h", cyc, {if0.led_lit, if0.led_out, if0.tick}, e0);
        end
        tests++;
        if ({if1.led_lit, if1.led_out, if1.tick} !== e1) begin
          fails++;
          $display("FAIL pwm_dut1 cyc=%0d got=%h exp=%h", cyc, {if1.led_lit, if1.led_out, if1.tick}, e1);
        end
      end
      want = (blist[j] == 4'd15) ? 32 : 2 * int'(blist[j]);
      tests++;
      if (on_cnt != want) begin
        fails++;
        $display("FAIL pwm_duty bright=%0d got=%0d exp=%0d", blist[j], on_cnt, want);
      end
    end
  endtask

  task automatic test_blink();
    logic [2*N:0] e0, e1;
    logic prev;
    int last;
    led_in = 8'h10;
    blink_en = 8'h10;
    brightness = 4'd15;
    last = -1;
    prev = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      e0 = m_exp(cyc, P0, H0, B0, I0);
      e1 = m_exp(cyc, P1, H1, B1, I1);
      tests++;
      if ({if0.led_lit, if0.led_out, if0.tick} !== e0) begin
        fails++;
        $display("FAIL blink_dut0 cyc=%0d got=%h exp=%h", cyc, {if0.led_lit, if0.led_out, if0.tick}, e0);
      end
      tests++;
      if ({if1.led_lit, if1.led_out, if1.tick} !== e1) begin
        fails++;
        $display("FAIL blink_dut1 cyc=%0d got=%h exp=%h", cyc, {if1.led_lit, if1.led_out, if1.tick}, e1);
      end
      if (k >= 20) begin
        tests++;
        if (if1.led_out[3:0] !== 4'hF) begin
          fails++;
          $display("FAIL blink_steady cyc=%0d got=%h exp=f", cyc, if1.led_out[3:0]);
        end
        if (k > 20 && if1.led_out[4] !== prev) begin
          if (last >= 0) begin
            tests++;
            if (cyc - last != 6) begin
              fails++;
              $display("FAIL blink_period cyc=%0d got=%0d exp=6", cyc, cyc - last);
            end
          end
          last = cyc;
        end
        prev = if1.led_out[4];
      end
    end
    tests++;
    if (last < 0) begin
      fails++;
      $display("FAIL blink_toggle got=none exp=toggles");
    end
  endtask

  task automatic test_random();
    logic [2*N:0] e0, e1;
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      e0 = m_exp(cyc, P0, H0, B0, I0);
      e1 = m_exp(cyc, P1, H1, B1, I1);
      tests++;
      if ({if0.led_lit, if0.led_out, if0.tick} !== e0) begin
        fails++;
        $display("FAIL random_dut0 cyc=%0d got=%h exp=%h", cyc, {if0.led_lit, if0.led_out, if0.tick}, e0);
      end
      tests++;
      if ({if1.led_lit, if1.led_out, if1.tick} !== e1) begin
        fails++;
        $display("FAIL random_dut1 cyc=%0d got=%h exp=%h", cyc, {if1.led_lit, if1.led_out, if1.tick}, e1);
      end
      for (int i = 0; i < N; i++) led_in[i] = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 31) == 0) blink_en = N'($urandom);
      if ($urandom_range(0, 47) == 0) brightness = 4'($urandom);
    end
  endtask

  task automatic test_async_reset();
    logic [2*N:0] e1;
    led_in = 8'h00;
    blink_en = 8'h00;
    brightness = 4'd15;
    repeat (20) @(negedge clk);
    led_in = 8'h04;
    @(negedge clk);
    led_in = 8'h00;
    repeat (4) @(negedge clk);
    e1 = m_exp(cyc, P1, H1, B1, I1);
    tests++;
    if ({if1.led_lit, if1.led_out, if1.tick} !== e1 || if1.led_lit[2] !== 1'b1) begin
      fails++;
      $display("FAIL pre_async_hold cyc=%0d got=%h exp=%h", cyc, {if1.led_lit, if1.led_out, if1.tick}, e1);
    end
    #1 rst = 1'b1;
    #1;
    tests++;
    if ({if1.led_lit, if1.led_out, if1.tick} !== {8'h00, 8'hFF, 1'b0}) begin
      fails++;
      $display("FAIL async_reset_dut1 got=%h exp=%h", {if1.led_lit, if1.led_out, if1.tick}, {8'h00, 8'hFF, 1'b0});
    end
    tests++;
    if ({if0.led_lit, if0.led_out, if0.tick} !== {8'h00, 8'h00, 1'b0}) begin
      fails++;
      $display("FAIL async_reset_dut0 got=%h exp=%h", {if0.led_lit, if0.led_out, if0.tick}, {8'h00, 8'h00, 1'b0});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      e1 = m_exp(cyc, P1, H1, B1, I1);
      tests++;
      if ({if1.led_lit, if1.led_out, if1.tick} !== e1) begin
        fails++;
        $display("FAIL after_async_dut1 cyc=%0d got=%h exp=%h", cyc, {if1.led_lit, if1.led_out, if1.tick}, e1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_short_pulse();
    test_retrigger();
    test_pwm();
    test_blink();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/led_activity_driver.md
Name: led_activity_driver

Overview:
- Sits directly downstream of the indicator block. Consumes its 8-bit green-LED vector, in which the disk-activity bits are short, often single-cycle pulses, and drives the board LED pins.
- Stretches each activity pulse to a visible minimum on-time and applies global PWM brightness.
- Optionally blinks selected channels, for example fifo_full, so that status conditions stay distinguishable.

Parameters:
- N, 8: number of LED channels.
- PRESCALE, 28000: clk cycles per tick (1 kHz at 28 MHz). Legal range 2..2^20.
- HOLD, 50: ticks a channel stays lit after its input falls. Legal range 1..255.
- BLINK, 250: ticks per blink half-period. Legal range 1..1023.
- INV, 0: when 1, led_out is active-low.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset, asynchronous, active-high.
- led_in, in, N: raw indicator vector, same clock domain as clk.
- blink_en, in, N: per-channel blink enable.
- brightness, in, 4: global duty. 0 = off; 1..14 = brightness/16 duty; 15 = always on.
- led_lit, out, N: stretched, unmodulated channel state, active-high.
- led_out, out, N: final pin drive, including PWM, blink and INV.
- tick, out, 1: one-cycle strobe at the prescaler rate.

Behaviour:
- Reset: prescaler, PWM counter, hold counters and blink counter are 0; every channel is in IDLE; blink phase is 1 (visible).
  - Outputs during reset: led_lit = 0 and tick = 0.
  - led_out = all 0 if INV = 0, all 1 if INV = 1.
  - Reset asserted mid-hold forces IDLE immediately (asynchronously).
- Input register: led_in is registered once into in_q. All decisions use in_q.
- Prescaler: counts 0..PRESCALE-1 and wraps to 0. tick is registered and asserts for exactly 1 cycle per wrap.
- Per-channel FSM:
  - IDLE: in_q = 1 → ACTIVE.
  - ACTIVE: when in_q = 0, go to HOLD and load hold_cnt = HOLD.
  - HOLD:
    - If in_q = 1 → ACTIVE. This wins over tick and over expiry.
    - Else, on tick, decrement hold_cnt. If hold_cnt = 1 at that tick → IDLE.
  - Lit state: lit = (state != IDLE).
  - Visible hold after the input falls: HOLD-1 to HOLD full ticks. A 1-cycle input pulse therefore produces at least HOLD-1 ticks of light.
- led_lit is registered from lit. Latency: led_in rising at edge n → led_lit = 1 after edge n+2.
- Blink:
  - The blink counter increments on tick and runs 0..BLINK-1.
  - At wrap it toggles blink phase. Phase is free-running regardless of channel state.
  - vis[i] = lit[i] & (~blink_en[i] | phase).
- PWM:
  - pwm_cnt is 4 bits, increments every clk, wraps 15 → 0.
  - duty_on = (brightness == 15) | (pwm_cnt < brightness).
  - led_out is registered: led_out[i] = (vis[i] & duty_on) ^ INV. It has the same latency as led_lit.
- Changes to brightness and blink_en take effect on the next cycle. No glitch filtering is applied.
- All counters use unsigned arithmetic with widths sized to their parameter range. There is no overflow anywhere else.

Test Plan:
- Reset release with led_in = 0, brightness = 15, INV = 0 → led_out = 0x00, led_lit = 0x00, tick first pulses at cycle PRESCALE after reset release.
- Short pulse: PRESCALE = 4, HOLD = 3, a 1-cycle pulse on led_in[0] → led_lit[0] rises 2 cycles later and falls after 2..3 ticks (8..12 cycles). Other bits stay 0.
- Retrigger: a second pulse on bit 1 while it is in HOLD (hold_cnt = 1, coinciding with tick) → stays lit with no gap and reloads HOLD after the new falling edge.
- PWM: led_in = 0xFF held, brightness = 4 → each led_out bit is high exactly 4 of every 16 cycles. brightness = 0 → constant 0; brightness = 15 → constant 1.
- Blink: PRESCALE = 2, BLINK = 3, blink_en = 0x10, led_in[4] held high → led_out[4] toggles every 6 cycles while led_out[0..3] stays steady.
- Asynchronous reset asserted mid-HOLD with INV = 1 → led_out = 0xFF and led_lit = 0x00 immediately, without waiting for a clk edge.
